// File: rtl/ram_port_initiator_pkg.sv
// rtl/ram_port_initiator_pkg.sv - shared parameters and helpers for the RAM port initiator
package ram_port_initiator_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 10;
   localparam int DEF_RSP_DEPTH  = 4;

   // Smallest n with 2**n >= value; constant-foldable for pointer widths.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/ram_port_initiator_fifo.sv
// rtl/ram_port_initiator_fifo.sv - circular response buffer with pointer/count control
module ram_port_initiator_fifo
   import ram_port_initiator_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_RSP_DEPTH,
   localparam int PW        = clog2(DEPTH),
   localparam int CW        = clog2(DEPTH) + 1
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_push,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic                  i_pop,
   output logic [DATA_WIDTH-1:0] o_rdata,
   output logic                  o_empty,
   output logic [CW-1:0]         o_count
);

   logic [PW-1:0]         r_wr_ptr;
   logic [PW-1:0]         r_rd_ptr;
   logic [CW-1:0]         r_count;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   logic w_full;
   logic w_do_pop;

   assign w_full   = (r_count == CW'(DEPTH));
   assign o_empty  = (r_count == '0);
   assign o_count  = r_count;
   assign o_rdata  = r_mem[r_rd_ptr];
   assign w_do_pop = i_pop && !o_empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
            r_wr_ptr        <= r_wr_ptr + PW'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         if (i_push && !w_do_pop) begin
            r_count <= r_count + CW'(1);
         end else if (!i_push && w_do_pop) begin
            r_count <= r_count - CW'(1);
         end
      end
   end

   // The upstream credit check guarantees a free slot for every push.
   a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(i_push && w_full));

endmodule

// File: rtl/ram_port_initiator.sv
// rtl/ram_port_initiator.sv - turns a request stream into RAM port cycles, buffers read data
module ram_port_initiator
   import ram_port_initiator_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int RSP_DEPTH  = DEF_RSP_DEPTH
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  ram_en,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_din,
   input  logic [DATA_WIDTH-1:0] ram_dout
);

   localparam int CW = clog2(RSP_DEPTH) + 1;

   logic          r_rd_pend;
   logic          w_accept;
   logic          w_rd_issue;
   logic          w_pop;
   logic          w_empty;
   logic [CW-1:0] w_count;
   logic [CW:0]   w_credit_used;

   // Credit counts the read in flight plus buffered entries, from registered state only,
   // so req_ready never depends combinationally on rsp_ready or req_valid.
   assign w_credit_used = {1'b0, w_count} + (CW+1)'(r_rd_pend);
   assign req_ready     = (w_credit_used < (CW+1)'(RSP_DEPTH));

   assign w_accept   = req_valid && req_ready;
   assign w_rd_issue = w_accept && !req_we;
   assign ram_en     = w_accept;
   assign ram_we     = req_we;
   assign ram_addr   = req_addr;
   assign ram_din    = req_wdata;

   assign rsp_valid = !w_empty;
   assign w_pop     = rsp_valid && rsp_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_pend <= 1'b0;
      end else begin
         r_rd_pend <= w_rd_issue;
      end
   end

   // ram_dout is captured only in the cycle right after a read issue.
   ram_port_initiator_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (r_rd_pend),
      .i_wdata (ram_dout),
      .i_pop   (w_pop),
      .o_rdata (rsp_rdata),
      .o_empty (w_empty),
      .o_count (w_count)
   );

endmodule

// File: tb/tb_ram_port_initiator.sv
// tb/tb_ram_port_initiator.sv - directed self-checking bench with a behavioural RAM port
module tb_ram_port_initiator;

   localparam int DW = 32;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_we = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [DW-1:0] rsp_rdata;
   logic          ram_en;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   logic [DW-1:0] ram_mem [0:1023];
   logic [DW-1:0] rsp_q [$];
   int            rsp_cyc_q [$];

   always #5 clk = ~clk;

   ram_port_initiator #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .RSP_DEPTH  (4)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .ram_en    (ram_en),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_din   (ram_din),
      .ram_dout  (ram_dout)
   );

   // Port A of the RAM: registered read, write lands at the enabled edge.
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) begin
            ram_mem[ram_addr] <= ram_din;
         end else begin
            ram_dout <= ram_mem[ram_addr];
         end
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst && rsp_valid && rsp_ready) begin
         rsp_q.push_back(rsp_rdata);
         rsp_cyc_q.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(posedge clk);
      #1;
      req_valid = v;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int acc;
      int drops;
      int bad;
      int idx;
      int guard;
      int c0;
      logic tog;

      idle(3);
      rst = 1'b0;
      @(negedge clk);
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_req_ready", req_ready, 1);
      check("reset_rsp_rdata", rsp_rdata, 0);
      check("reset_ram_en", ram_en, 0);

      // Test 1: write then read, latency 2
      rsp_ready = 1'b1;
      drive(1, 1, 10'h005, 32'hDEADBEEF);
      @(negedge clk);
      check("t1_wr_en", ram_en, 1);
      check("t1_wr_we", ram_we, 1);
      drive(1, 0, 10'h005, 0);
      @(negedge clk);
      check("t1_rd_en", {ram_en, ram_we}, 2'b10);
      drive(0, 0, 0, 0);
      @(negedge clk);
      check("t1_valid_n1", rsp_valid, 0);
      @(negedge clk);
      check("t1_valid_n2", rsp_valid, 1);
      check("t1_rdata", rsp_rdata, 32'hDEADBEEF);
      @(negedge clk);
      check("t1_popped", rsp_valid, 0);

      for (int i = 0; i < 32; i++) begin
         drive(1, 1, AW'(i), DW'(i * 3));
      end
      drive(0, 0, 0, 0);
      idle(1);
      rsp_q.delete();
      rsp_cyc_q.delete();

      // Test 2: back-to-back reads
      drops = 0;
      c0 = 0;
      for (int i = 0; i < 8; i++) begin
         drive(1, 0, AW'(i), 0);
         @(negedge clk);
         if (i == 0) c0 = cyc;
         if (!req_ready) drops++;
      end
      drive(0, 0, 0, 0);
      idle(4);
      check("t2_ready_drops", drops, 0);
      check("t2_count", rsp_q.size(), 8);
      bad = 0;
      for (int i = 0; i < rsp_q.size(); i++) begin
         if (rsp_q[i] !== DW'(i * 3)) bad++;
         if (rsp_cyc_q[i] != rsp_cyc_q[0] + i) bad++;
      end
      check("t2_data_consecutive", bad, 0);
      if (rsp_cyc_q.size() > 0) check("t2_latency", rsp_cyc_q[0] - c0, 2);

      // Test 3: stalled consumer fills the buffer
      rsp_q.delete();
      rsp_ready = 1'b0;
      acc = 0;
      for (int i = 0; i < 6; i++) begin
         drive(1, 0, AW'(8 + i), 0);
         @(negedge clk);
         if (req_ready) acc++;
      end
      drive(0, 0, 0, 0);
      idle(2);
      @(negedge clk);
      check("t3_accepted", acc, 4);
      check("t3_req_ready", req_ready, 0);
      check("t3_cnt", u_dut.u_rsp_fifo.r_count, 4);
      check("t3_rsp_valid", rsp_valid, 1);
      idle(1);
      rsp_ready = 1'b1;
      idle(8);
      @(negedge clk);
      check("t3_count", rsp_q.size(), 4);
      bad = 0;
      for (int i = 0; i < rsp_q.size(); i++) begin
         if (rsp_q[i] !== DW'((8 + i) * 3)) bad++;
      end
      check("t3_order", bad, 0);
      check("t3_ready_back", req_ready, 1);

      // Test 4: pointer wrap with toggling rsp_ready
      rsp_q.delete();
      idx = 0;
      guard = 0;
      tog = 1'b0;
      while (idx < 20 && guard < 200) begin
         @(posedge clk);
         #1;
         tog = ~tog;
         rsp_ready = tog;
         req_valid = 1'b1;
         req_we    = 1'b0;
         req_addr  = AW'(idx);
         @(negedge clk);
         if (req_ready) idx++;
         guard++;
      end
      drive(0, 0, 0, 0);
      rsp_ready = 1'b1;
      idle(10);
      check("t4_issued", idx, 20);
      check("t4_count", rsp_q.size(), 20);
      bad = 0;
      for (int i = 0; i < rsp_q.size(); i++) begin
         if (rsp_q[i] !== DW'(i * 3)) bad++;
      end
      check("t4_order", bad, 0);

      // Test 5: address edges, read right after write
      rsp_q.delete();
      drive(1, 1, 10'h3FF, 32'hA5A50001);
      drive(1, 0, 10'h3FF, 0);
      drive(1, 1, 10'h000, 32'h5A5A0002);
      drive(1, 0, 10'h000, 0);
      drive(1, 0, 10'h001, 0);
      drive(0, 0, 0, 0);
      idle(5);
      check("t5_count", rsp_q.size(), 3);
      if (rsp_q.size() == 3) begin
         check("t5_3ff", rsp_q[0], 32'hA5A50001);
         check("t5_000", rsp_q[1], 32'h5A5A0002);
         check("t5_001", rsp_q[2], 32'd3);
      end

      // Test 6: reset with two buffered entries and one read in flight
      rsp_q.delete();
      rsp_ready = 1'b0;
      drive(1, 0, 10'd1, 0);
      drive(1, 0, 10'd2, 0);
      drive(0, 0, 0, 0);
      idle(2);
      check("t6_cnt_before", u_dut.u_rsp_fifo.r_count, 2);
      drive(1, 0, 10'd4, 0);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("t6_valid_drop", rsp_valid, 0);
      check("t6_rdata_clear", rsp_rdata, 0);
      idle(1);
      rst = 1'b0;
      @(negedge clk);
      check("t6_ready_after", req_ready, 1);
      check("t6_valid_after", rsp_valid, 0);
      rsp_ready = 1'b1;
      drive(1, 0, 10'd7, 0);
      drive(0, 0, 0, 0);
      idle(4);
      check("t6_count", rsp_q.size(), 1);
      if (rsp_q.size() == 1) check("t6_fresh", rsp_q[0], 32'd21);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
